// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame capture, E0/F0 prefix decoding
// and a held-direction vector. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2CLK,
    input  logic       iPS2D,
    output logic       o_valid,
    output logic [7:0] o_scancode,
    output logic       o_extended,
    output logic       o_break,
    output logic [3:0] o_direccion,
    output logic       o_frame_err,
    output logic       o_parity_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [7:0]    run_q, run_d;
    logic          edge_any, fall, timeout;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    state_t        state_q, state_d;
    logic [10:0]   shift_q, shift_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
    logic          valid_q, valid_d, ext_q, ext_d, brk_q, brk_d, ferr_q, ferr_d;
    logic [7:0]    code_q, code_d;
    logic [3:0]    dir_q, dir_d, dir_mask;
    logic [7:0]    rx_byte;

`ifdef PS2_PARITY_CHECK_EN
    logic          perr_q, perr_d;
`else
    logic          parity_unused;
    assign parity_unused = shift_q[9];
`endif

    assign rx_byte = shift_q[8:1];

    // Run-length filter: the level only follows the synchronised line after FILTER_LEN agreeing samples.
    always_comb begin
        filt_d   = filt_q;
        run_d    = '0;
        edge_any = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (run_q == 8'(FILTER_LEN - 1)) begin
                filt_d   = clk_sync_q;
                edge_any = 1'b1;
            end else begin
                run_d = run_q + 8'd1;
            end
        end
        fall = edge_any && filt_q;
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (edge_any) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES)) && (state_q == ST_SHIFT);
    end

    // Exact match on {extended, code}; E0 variants of the plain codes are not directions.
    always_comb begin
        dir_mask = 4'b0000;
        case ({pend_ext_q, rx_byte})
            9'h01C, 9'h16B: dir_mask = 4'b0001;
            9'h01B, 9'h172: dir_mask = 4'b0010;
            9'h023, 9'h174: dir_mask = 4'b0100;
            9'h01D, 9'h175: dir_mask = 4'b1000;
            default:        dir_mask = 4'b0000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        code_d     = code_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        dir_d      = dir_q;
`ifdef PS2_PARITY_CHECK_EN
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_sync_q) begin
                    shift_d  = {dat_sync_q, shift_q[10:1]};
                    bitcnt_d = 4'd1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_d  = {dat_sync_q, shift_q[10:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) begin
                        state_d = ST_CHECK;
                    end
                end else if (timeout) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = 4'd0;
                    ferr_d   = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d  = ST_IDLE;
                bitcnt_d = 4'd0;
                if (shift_q[0] || !shift_q[10]) begin
                    ferr_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                end else if (!(^shift_q[9:1])) begin
                    perr_d = 1'b1;
`endif
                end else if (rx_byte == 8'hE0) begin
                    pend_ext_d = 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    pend_brk_d = 1'b1;
                end else begin
                    valid_d    = 1'b1;
                    code_d     = rx_byte;
                    ext_d      = pend_ext_q;
                    brk_d      = pend_brk_q;
                    pend_ext_d = 1'b0;
                    pend_brk_d = 1'b0;
                    dir_d      = pend_brk_q ? (dir_q & ~dir_mask) : (dir_q | dir_mask);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            run_q      <= '0;
            to_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            dir_q      <= '0;
        end else begin
            clk_meta_q <= iPS2CLK;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= iPS2D;
            dat_sync_q <= dat_meta_q;
            filt_q     <= filt_d;
            run_q      <= run_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            dir_q      <= dir_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_valid     = valid_q;
    assign o_scancode  = code_q;
    assign o_extended  = ext_q;
    assign o_break     = brk_q;
    assign o_direccion = dir_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed PS/2 frames against a frame-level key model.
module tb_ps2_key_decoder;
    localparam int FLEN    = 8;
    localparam int TOUT    = 400;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iPS2CLK = 1'b1;
    logic       iPS2D = 1'b1;
    logic       o_valid, o_extended, o_break, o_frame_err, o_parity_err;
    logic [7:0] o_scancode;
    logic [3:0] o_direccion;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] pulses;   // {valid, frame_err, parity_err}
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] dir;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] cur_dir = 4'd0;
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [3:0] m_dir = 4'd0;

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .Clock(Clock), .Reset(Reset), .iPS2CLK(iPS2CLK), .iPS2D(iPS2D),
        .o_valid(o_valid), .o_scancode(o_scancode), .o_extended(o_extended),
        .o_break(o_break), .o_direccion(o_direccion), .o_frame_err(o_frame_err),
        .o_parity_err(o_parity_err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Key-level model: which direction a {prefix, code} pair names.
    function automatic logic [3:0] dir_of(input logic ext, input logic [7:0] code);
        logic [7:0] plain [4];
        logic [7:0] extd  [4];
        logic [3:0] m;
        plain = '{8'h1C, 8'h1B, 8'h23, 8'h1D};
        extd  = '{8'h6B, 8'h72, 8'h74, 8'h75};
        m = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if ((!ext && code == plain[i]) || (ext && code == extd[i])) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        exp_t e;
        e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0;
        if (bad_stop) begin
            e.pulses = 3'b010; e.dir = m_dir; exp_q.push_back(e);
        end else if (PAR_EN && bad_par) begin
            e.pulses = 3'b001; e.dir = m_dir; exp_q.push_back(e);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_brk) m_dir = m_dir & ~dir_of(m_ext, b);
            else       m_dir = m_dir | dir_of(m_ext, b);
            e.pulses = 3'b100; e.code = b; e.ext = m_ext; e.brk = m_brk; e.dir = m_dir;
            exp_q.push_back(e);
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            iPS2D = f[i];
            wait_cyc(15);
            iPS2CLK = 1'b0;
            wait_cyc(30);
            iPS2CLK = 1'b1;
            wait_cyc(15);
        end
        iPS2D = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        model_frame(b, bad_par, bad_stop);
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        wait_cyc(40);
        chk($sformatf("drained_%02h", b), exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_code"}, o_scancode, 0);
        chk({tag, "_ext"}, o_extended, 0);
        chk({tag, "_brk"}, o_break, 0);
        chk({tag, "_dir"}, o_direccion, 0);
        chk({tag, "_ferr"}, o_frame_err, 0);
        chk({tag, "_perr"}, o_parity_err, 0);
    endtask

    // Compare process: every pulse must match the model's next expectation; direction holds otherwise.
    always @(negedge Clock) begin
        if (Reset) begin
            cur_dir = 4'd0;
        end else if (o_valid || o_frame_err || o_parity_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse got valid/ferr/perr=%b%b%b expected=none code=%02h",
                         o_valid, o_frame_err, o_parity_err, o_scancode);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulses", {o_valid, o_frame_err, o_parity_err}, e.pulses);
                if (e.pulses[2]) begin
                    chk("scancode", o_scancode, e.code);
                    chk("extended", o_extended, e.ext);
                    chk("break", o_break, e.brk);
                end
                chk("dir_event", o_direccion, e.dir);
                cur_dir = e.dir;
            end
        end else begin
            chk("dir_hold", o_direccion, cur_dir);
        end
    end

    initial begin
        wait_cyc(3);
        check_all_zero("reset");
        Reset = 1'b0;
        wait_cyc(20);

        // Make A
        send_frame(8'h1C, 0, 0);
        chk("makeA_code", o_scancode, 8'h1C);
        chk("makeA_brk", o_break, 0);
        chk("makeA_dir", o_direccion, 4'b0001);

        // Release A
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("relA_brk", o_break, 1);
        chk("relA_dir", o_direccion, 4'b0000);

        // Make W, make E0 74, release E0 F0 74
        send_frame(8'h1D, 0, 0);
        chk("makeW_dir", o_direccion, 4'b1000);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        chk("right_ext", o_extended, 1);
        chk("right_dir", o_direccion, 4'b1100);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h74, 0, 0);
        chk("relright_dir", o_direccion, 4'b1000);

        // Wrong parity on 1D
        send_frame(8'h1D, 1, 0);
        chk("par_dir", o_direccion, 4'b1000);

        // Timeout after 5 bits, then 1B decodes
        model_frame(8'h00, 0, 1);
        send_bits({1'b1, 1'b1, 8'h1B, 1'b0}, 5);
        wait_cyc(TOUT + 60);
        chk("timeout_drained", exp_q.size(), 0);
        send_frame(8'h1B, 0, 0);
        chk("after_to_down", o_direccion[1], 1);
        chk("after_to_dir", o_direccion, 4'b1010);

        // Reset mid-frame, then 23
        send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 5);
        @(negedge Clock);
        Reset = 1'b1;
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_dir = 4'd0;
        wait_cyc(2);
        check_all_zero("midreset");
        Reset = 1'b0;
        wait_cyc(20);
        send_frame(8'h23, 0, 0);
        chk("after_rst_dir", o_direccion, 4'b0100);

        // Glitches shorter than the filter must not start a frame
        for (int g = 0; g < 5; g++) begin
            iPS2CLK = 1'b0;
            wait_cyc(3);
            iPS2CLK = 1'b1;
            wait_cyc(12);
        end
        wait_cyc(30);
        chk("glitch_code", o_scancode, 8'h23);
        chk("glitch_dir", o_direccion, 4'b0100);
        send_frame(8'h1A, 0, 0);
        chk("unmapped_code", o_scancode, 8'h1A);
        chk("unmapped_dir", o_direccion, 4'b0100);

        // Bad stop between F0 and 23 keeps the pending break
        send_frame(8'hF0, 0, 0);
        send_frame(8'h5A, 0, 1);
        send_frame(8'h23, 0, 0);
        chk("brk_kept_dir", o_direccion, 4'b0000);
        chk("brk_kept_flag", o_break, 1);

        wait_cyc(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and key-event decoder. It runs entirely in the system clock domain. It synchronises and deglitches the raw PS/2 clock and data lines, assembles 11-bit frames, and decodes the E0 (extended) and F0 (break) prefixes into single key events. It keeps a held-direction vector for the game controller, so directions are cleared on key release. This lets the controller read held keys directly, without tracking scan codes itself.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level (range 2–255).
- `TIMEOUT_CYCLES`, default 50000: system cycles with no filtered PS/2 clock edge before a partial frame is aborted.
- `Clock`, input, 1: system clock; all logic is on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `iPS2CLK`, input, 1: raw PS/2 clock, asynchronous.
- `iPS2D`, input, 1: raw PS/2 data, asynchronous.
- `o_valid`, output, 1: one-cycle pulse; a complete key event is present on `o_scancode`, `o_extended` and `o_break`.
- `o_scancode`, output, 8: final scan-code byte of the event; held until the next event.
- `o_extended`, output, 1: the event was preceded by E0.
- `o_break`, output, 1: the event was preceded by F0 (key release).
- `o_direccion`, output, 4: held directions; bit0 = left, bit1 = down, bit2 = right, bit3 = up.
- `o_frame_err`, output, 1: one-cycle pulse on a bad start/stop bit or a timeout abort.
- `o_parity_err`, output, 1: one-cycle pulse on an odd-parity failure (see Configuration).

## Operation
- Input conditioning:
  - Both PS/2 lines pass through a 2-flop synchroniser.
  - The clock line then passes through a FILTER_LEN run-length filter.
  - A falling edge on the filtered clock is `fall`. Synchronised data is sampled on `fall`.
- Frame FSM:
  - IDLE: on `fall` with data = 0, go to SHIFT with bitcount = 1. On `fall` with data = 1, stay in IDLE (no error).
  - SHIFT: each `fall` shifts data in LSB-first and increments bitcount. When bitcount reaches 11, go to CHECK.
  - CHECK (one cycle): validate the start bit (0), the stop bit (1) and parity, then return to IDLE.
  - Frame layout: bit0 = start, bits1–8 = data LSB-first, bit9 = odd parity, bit10 = stop.
- Timeout:
  - A counter clears on every filtered edge.
  - If it reaches TIMEOUT_CYCLES while in SHIFT: return to IDLE, set bitcount = 0, pulse `o_frame_err`.
- Byte decoder (only for good frames):
  - E0: set the `pend_ext` flag.
  - F0: set the `pend_brk` flag.
  - Any other byte: emit an event with `o_extended = pend_ext` and `o_break = pend_brk`, then clear both flags.
  - Bad frames leave both flags unchanged.
- Direction map. Each mapped key sets its bit on make and clears it on break. Bits are independent, so several may be set at once.
  - Left: 1C, or E0 6B.
  - Down: 1B, or E0 72.
  - Right: 23, or E0 74.
  - Up: 1D, or E0 75.
  - An unmapped key emits an event but does not change `o_direccion`.
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE, flags and counters are cleared, and the filter state is set to 1 (idle-high).
  - Reset mid-frame discards the partial frame; the next frame is received normally.

## Timing
- A raw edge reaches `fall` after 2 (synchroniser) + FILTER_LEN cycles.
- The 11th `fall` moves the FSM to CHECK on the next cycle.
- `o_valid`, `o_scancode`, `o_extended`, `o_break`, `o_direccion` and the error pulses all update in the cycle after CHECK.
- Latency is therefore 2 cycles from the cycle `fall` is detected.
- `o_valid` and the error pulses are never asserted together.
- Prefix bytes (E0, F0) never pulse `o_valid`.
- There is no back-pressure: the consumer must sample on `o_valid`. Events are at least 11 PS/2 clocks apart.
- Glitches shorter than FILTER_LEN cycles on `iPS2CLK` produce no `fall`.
- The timeout counter saturates at TIMEOUT_CYCLES; it does not wrap.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - A frame with even parity over bits 1–9 pulses `o_parity_err`.
  - The byte is discarded: no event, no flag change, `o_direccion` unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - Parity is ignored and `o_parity_err` is tied to 0.
  - Start/stop checking and timeout behaviour are unchanged.

## Test plan
- Make A: frame 1C with parity 0 and stop 1 → `o_valid` pulse, `o_scancode` = 1C, `o_extended` = 0, `o_break` = 0, `o_direccion` = 0001.
- Release A: frames F0, 1C → no `o_valid` on F0. On 1C: `o_valid`, `o_break` = 1, `o_direccion` = 0000.
- Two keys and an extended key:
  - Make W then make E0 74 → `o_direccion` = 1000, then 1100, with `o_extended` = 1 on the second event.
  - Then E0 F0 74 → `o_direccion` = 1000.
- Parity error: 1D sent with the wrong parity bit.
  - Macro defined: `o_parity_err` pulses, no `o_valid`, `o_direccion` unchanged.
  - Macro undefined: `o_valid` with 1D.
- Timeout and reset:
  - Stop the clock after 5 bits for TIMEOUT_CYCLES → `o_frame_err` pulse; a following 1B frame decodes with `o_direccion` bit1 set.
  - Assert `Reset` mid-frame → all outputs 0; the next 23 frame gives `o_direccion` = 0100.
- Glitch rejection: 3-cycle low pulses on `iPS2CLK` with FILTER_LEN = 8 → no bit shifted and no output change.
